pkt_rx_checker: RTL

- Downstream consumer of the packet forwarding stage's transmit byte stream (txd/tx_vld).
- Frames bytes into packets, checks each length against programmable min/max bounds, and computes a per-packet XOR checksum.
- Keeps saturating packet, error and byte statistics, readable and clearable over the same addr/din/rw/dout register bus style as the forwarding stage.
- Serves as the end-of-chain monitor in the testbench and on-chip statistics block.

---
 rtl/pkt_rx_checker_if.sv | 29 ++
 rtl/pkt_rx_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_checker_if.sv
// ============================================================================
// Module  : pkt_rx_checker_if
// Brief   : Register bus and receive byte stream bundle for pkt_rx_checker.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface pkt_rx_checker_if;
  logic [7:0]  addr;
  logic [31:0] din;
  logic        rw;
  logic [31:0] dout;
  logic [7:0]  rxd;
  logic        rx_vld;
  logic        pkt_done;
  logic        pkt_err;

  modport master (
    output addr, din, rw, rxd, rx_vld,
    input  dout, pkt_done, pkt_err
  );

  modport slave (
    input  addr, din, rw, rxd, rx_vld,
    output dout, pkt_done, pkt_err
  );
endinterface

`default_nettype wire

// File: rtl/pkt_rx_checker.sv
// ============================================================================
// Module  : pkt_rx_checker
// Brief   : Packet framer with length bounds check, XOR checksum and stats.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pkt_rx_checker #(
  parameter int MIN_DEFAULT = 64,
  parameter int MAX_DEFAULT = 512,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  pkt_rx_checker_if.slave bus
);

  localparam logic [7:0]       c_ADDR_CTRL = 8'h00;
  localparam logic [7:0]       c_ADDR_MIN  = 8'h04;
  localparam logic [7:0]       c_ADDR_MAX  = 8'h08;
  localparam logic [7:0]       c_ADDR_PKT  = 8'h0C;
  localparam logic [7:0]       c_ADDR_ERR  = 8'h10;
  localparam logic [7:0]       c_ADDR_BYTE = 8'h14;
  localparam logic [7:0]       c_ADDR_LAST = 8'h18;
  localparam logic [9:0]       c_MIN_FLOOR = 10'd64;
  localparam logic [9:0]       c_MAX_CEIL  = 10'd512;
  localparam logic [9:0]       c_LEN_SAT   = 10'd1023;
  localparam logic [9:0]       c_MIN_RST   = 10'(MIN_DEFAULT);
  localparam logic [9:0]       c_MAX_RST   = 10'(MAX_DEFAULT);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    SKIP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_enable;
  logic [9:0]       r_min;
  logic [9:0]       r_max;
  logic [9:0]       r_len;
  logic [7:0]       r_csum;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [31:0]      r_byte_cnt;
  logic [9:0]       r_last_len;
  logic [7:0]       r_last_csum;

  logic             w_start;
  logic             w_accum;
  logic             w_done;
  logic             w_err;
  logic             w_len_err;
  logic             w_wr_ctrl;
  logic             w_wr_min;
  logic             w_wr_max;
  logic             w_clear;
  logic [9:0]       w_din_len;
  logic [32:0]      w_byte_sum;
  logic [31:0]      w_dout;

  assign w_wr_ctrl  = !bus.rw && (bus.addr == c_ADDR_CTRL);
  assign w_wr_min   = !bus.rw && (bus.addr == c_ADDR_MIN);
  assign w_wr_max   = !bus.rw && (bus.addr == c_ADDR_MAX);
  assign w_clear    = w_wr_ctrl && bus.din[1];
  assign w_din_len  = bus.din[9:0];
  assign w_len_err  = (r_len < r_min) || (r_len > r_max);
  assign w_byte_sum = {1'b0, r_byte_cnt} + {23'd0, r_len};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Enable is only consulted when a packet starts (IDLE or back-to-back in CHECK).
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accum     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rx_vld) begin
          if (r_enable) begin
            w_state_nxt = RECV;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = SKIP;
          end
        end
      end
      RECV: begin
        if (bus.rx_vld) begin
          w_accum = 1'b1;
        end else begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_done = 1'b1;
        w_err  = w_len_err;
        if (bus.rx_vld) begin
          if (r_enable) begin
            w_state_nxt = RECV;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = SKIP;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SKIP: begin
        if (!bus.rx_vld) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.pkt_done = w_done;
  assign bus.pkt_err  = w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= 10'd0;
      r_csum <= 8'd0;
    end else if (w_start) begin
      r_len  <= 10'd1;
      r_csum <= bus.rxd;
    end else if (w_accum) begin
      r_len  <= (r_len == c_LEN_SAT) ? r_len : r_len + 10'd1;
      r_csum <= r_csum ^ bus.rxd;
    end
  end

  // New bounds must keep min < max so a write that would invert them is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_min    <= c_MIN_RST;
      r_max    <= c_MAX_RST;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= bus.din[0];
      end
      if (w_wr_min && (w_din_len >= c_MIN_FLOOR) && (w_din_len < r_max)) begin
        r_min <= w_din_len;
      end
      if (w_wr_max && (w_din_len <= c_MAX_CEIL) && (w_din_len > r_min)) begin
        r_max <= w_din_len;
      end
    end
  end

  // Clear takes priority over a coincident packet update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_byte_cnt  <= 32'd0;
      r_last_len  <= 10'd0;
      r_last_csum <= 8'd0;
    end else if (w_clear) begin
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_byte_cnt  <= 32'd0;
      r_last_len  <= 10'd0;
      r_last_csum <= 8'd0;
    end else if (w_done) begin
      if (r_pkt_cnt != '1) begin
        r_pkt_cnt <= r_pkt_cnt + c_CNT_ONE;
      end
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + c_CNT_ONE;
      end
      r_byte_cnt  <= w_byte_sum[32] ? 32'hFFFF_FFFF : w_byte_sum[31:0];
      r_last_len  <= r_len;
      r_last_csum <= r_csum;
    end
  end

  always_comb begin
    w_dout = 32'd0;
    case (bus.addr)
      c_ADDR_CTRL: w_dout = {31'd0, r_enable};
      c_ADDR_MIN:  w_dout = {22'd0, r_min};
      c_ADDR_MAX:  w_dout = {22'd0, r_max};
      c_ADDR_PKT:  w_dout = 32'(r_pkt_cnt);
      c_ADDR_ERR:  w_dout = 32'(r_err_cnt);
      c_ADDR_BYTE: w_dout = r_byte_cnt;
      c_ADDR_LAST: w_dout = {8'h00, r_last_csum, 6'h00, r_last_len};
      default:     w_dout = 32'd0;
    endcase
  end

  assign bus.dout = w_dout;

endmodule

`default_nettype wire
